// File: rtl/scroll_pkg.sv
// Character codes, segment patterns and FSM state type shared by the
// scrolling word display and its segment decoder.
package scroll_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE,
    ST_SCROLL,
    ST_HOLD
  } state_e;

  localparam logic [2:0] CH_H     = 3'd0;
  localparam logic [2:0] CH_E     = 3'd1;
  localparam logic [2:0] CH_L     = 3'd2;
  localparam logic [2:0] CH_O     = 3'd3;
  localparam logic [2:0] CH_P     = 3'd4;
  localparam logic [2:0] CH_A     = 3'd5;
  localparam logic [2:0] CH_U     = 3'd6;
  localparam logic [2:0] CH_BLANK = 3'd7;

  // Active-low segments, bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_H     = 7'b1001000;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_L     = 7'b1110001;
  localparam logic [6:0] SEG_O     = 7'b0000001;
  localparam logic [6:0] SEG_P     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [2:0] reset_char(input int unsigned slot);
    case (slot)
      0:       return CH_H;
      1:       return CH_E;
      2, 3:    return CH_L;
      4:       return CH_O;
      default: return CH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/char_to_seg7.sv
// Combinational character-code to active-low seven-segment decoder.
module char_to_seg7
  import scroll_pkg::*;
#(
  parameter int unsigned CHAR_W = 3
) (
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (int'(code))
      int'(CH_H): seg = SEG_H;
      int'(CH_E): seg = SEG_E;
      int'(CH_L): seg = SEG_L;
      int'(CH_O): seg = SEG_O;
      int'(CH_P): seg = SEG_P;
      int'(CH_A): seg = SEG_A;
      int'(CH_U): seg = SEG_U;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scrolling_word_display.sv
// Scrolling message driver: writable character buffer rotated across the
// HEX digits on a divided tick, with pause/single-step and a hold after wrap.
module scrolling_word_display
  import scroll_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned CHAR_W     = 3,
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned HOLD_TICKS = 2
) (
  input  logic                       CLOCK_50,
  input  logic                       RESETN,
  input  logic                       RUN,
  input  logic                       DIR,
  input  logic                       STEP,
  input  logic                       WR_EN,
  input  logic [$clog2(MSG_LEN)-1:0] WR_ADDR,
  input  logic [CHAR_W-1:0]          WR_DATA,
  output logic [7*NUM_DIGITS-1:0]    HEX,
  output logic [$clog2(MSG_LEN)-1:0] PTR,
  output logic                       WRAP
);

  localparam int unsigned PTR_W  = $clog2(MSG_LEN);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  state_e                  state_q, state_d;
  logic [CHAR_W-1:0]       msg_q [MSG_LEN];
  logic [CHAR_W-1:0]       msg_d [MSG_LEN];
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic                    step_prev_q, step_prev_d;
  logic                    wrap_q, wrap_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [7*NUM_DIGITS-1:0] seg_all;

  logic tick;
  logic at_wrap;
  logic advance;

  assign tick    = (32'(tick_cnt_q) == TICK_DIV - 1);
  assign at_wrap = DIR ? (ptr_q == '0) : (ptr_q == PTR_W'(MSG_LEN - 1));

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    ptr_d       = ptr_q;
    wrap_d      = 1'b0;
    step_prev_d = STEP;
    advance     = 1'b0;
    hex_d       = seg_all;

    msg_d = msg_q;
    if (WR_EN && (32'(WR_ADDR) < MSG_LEN)) begin
      msg_d[WR_ADDR] = WR_DATA;
    end

    case (state_q)
      ST_PAUSE: begin
        if (RUN) begin
          state_d    = ST_SCROLL;
          tick_cnt_d = '0;
        end else if (STEP && !step_prev_q) begin
          advance = 1'b1;
        end
      end
      ST_SCROLL: begin
        if (!RUN) begin
          state_d = ST_PAUSE;
        end else begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
          if (tick) begin
            advance = 1'b1;
            if (at_wrap && (HOLD_TICKS > 0)) begin
              state_d    = ST_HOLD;
              hold_cnt_d = '0;
            end
          end
        end
      end
      ST_HOLD: begin
        if (!RUN) begin
          state_d = ST_PAUSE;
        end else begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
          if (tick) begin
            if (32'(hold_cnt_q) + 1 >= HOLD_TICKS) begin
              state_d    = ST_SCROLL;
              tick_cnt_d = '0;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_PAUSE;
    endcase

    if (advance) begin
      wrap_d = at_wrap;
      if (DIR) begin
        ptr_d = at_wrap ? PTR_W'(MSG_LEN - 1) : ptr_q - 1'b1;
      end else begin
        ptr_d = at_wrap ? '0 : ptr_q + 1'b1;
      end
    end
  end

  // Digit d shows msg[(ptr + NUM_DIGITS-1-d) mod MSG_LEN]; the sum never
  // reaches 2*MSG_LEN, so one conditional subtract replaces the modulo.
  for (genvar gd = 0; gd < NUM_DIGITS; gd++) begin : g_digit
    localparam int unsigned OFF = NUM_DIGITS - 1 - gd;
    logic [PTR_W-1:0]  idx;
    logic [CHAR_W-1:0] code;
    logic [6:0]        seg;

    always_comb begin
      if (32'(ptr_q) + OFF >= MSG_LEN) begin
        idx = PTR_W'(32'(ptr_q) + OFF - MSG_LEN);
      end else begin
        idx = PTR_W'(32'(ptr_q) + OFF);
      end
      code = msg_q[idx];
    end

    char_to_seg7 #(.CHAR_W(CHAR_W)) u_seg (
      .code (code),
      .seg  (seg)
    );

    assign seg_all[7*gd +: 7] = seg;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESETN) begin
      state_q     <= ST_PAUSE;
      ptr_q       <= '0;
      tick_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      step_prev_q <= 1'b0;
      wrap_q      <= 1'b0;
      hex_q       <= '1;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= CHAR_W'(reset_char(i));
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tick_cnt_q  <= tick_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      step_prev_q <= step_prev_d;
      wrap_q      <= wrap_d;
      hex_q       <= hex_d;
      msg_q       <= msg_d;
    end
  end

  assign HEX  = hex_q;
  assign PTR  = ptr_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_scrolling_word_display.sv
// Directed testbench for scrolling_word_display with a short tick divider.
module tb_scrolling_word_display;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned MSG_LEN    = 8;
  localparam int unsigned CHAR_W     = 3;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned HOLD_TICKS = 2;

  localparam logic [6:0] S_H  = 7'h48;
  localparam logic [6:0] S_E  = 7'h30;
  localparam logic [6:0] S_L  = 7'h71;
  localparam logic [6:0] S_O  = 7'h01;
  localparam logic [6:0] S_U  = 7'h41;
  localparam logic [6:0] S_A  = 7'h08;
  localparam logic [6:0] S_BL = 7'h7F;

  localparam logic [27:0] HEX_HELL = {S_H, S_E, S_L, S_L};
  localparam logic [27:0] HEX_ELLO = {S_E, S_L, S_L, S_O};
  localparam logic [27:0] HEX_BHEL = {S_BL, S_H, S_E, S_L};
  localparam logic [27:0] HEX_UELL = {S_U, S_E, S_L, S_L};
  localparam logic [27:0] HEX_UELA = {S_U, S_E, S_L, S_A};

  logic        CLOCK_50 = 1'b0;
  logic        RESETN   = 1'b0;
  logic        RUN      = 1'b0;
  logic        DIR      = 1'b0;
  logic        STEP     = 1'b0;
  logic        WR_EN    = 1'b0;
  logic [2:0]  WR_ADDR  = '0;
  logic [2:0]  WR_DATA  = '0;
  logic [27:0] HEX;
  logic [2:0]  PTR;
  logic        WRAP;

  int checks = 0;
  int errors = 0;

  scrolling_word_display #(
    .NUM_DIGITS (NUM_DIGITS),
    .MSG_LEN    (MSG_LEN),
    .CHAR_W     (CHAR_W),
    .TICK_DIV   (TICK_DIV),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESETN   (RESETN),
    .RUN      (RUN),
    .DIR      (DIR),
    .STEP     (STEP),
    .WR_EN    (WR_EN),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .HEX      (HEX),
    .PTR      (PTR),
    .WRAP     (WRAP)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic clk1();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    clk1();
    clk1();
    checks++;
    if (HEX !== 28'hFFFFFFF) begin
      errors++; $display("FAIL reset_hex: got %h expected %h", HEX, 28'hFFFFFFF);
    end
    checks++;
    if (PTR !== 3'd0) begin
      errors++; $display("FAIL reset_ptr: got %0d expected 0", PTR);
    end
    checks++;
    if (WRAP !== 1'b0) begin
      errors++; $display("FAIL reset_wrap: got %b expected 0", WRAP);
    end
    RESETN = 1'b1;
    clk1();
    clk1();
    checks++;
    if (HEX !== HEX_HELL) begin
      errors++; $display("FAIL idle_hex: got %h expected %h", HEX, HEX_HELL);
    end
    checks++;
    if (PTR !== 3'd0) begin
      errors++; $display("FAIL idle_ptr: got %0d expected 0", PTR);
    end
  endtask

  task automatic test_scroll_left();
    RUN = 1'b1;
    DIR = 1'b0;
    clk1();
    repeat (3) clk1();
    checks++;
    if (PTR !== 3'd0) begin
      errors++; $display("FAIL scroll_early: got %0d expected 0", PTR);
    end
    clk1();
    checks++;
    if (PTR !== 3'd1) begin
      errors++; $display("FAIL scroll_first_step: got %0d expected 1", PTR);
    end
    checks++;
    if (HEX !== HEX_HELL) begin
      errors++; $display("FAIL scroll_hex_lag: got %h expected %h", HEX, HEX_HELL);
    end
    clk1();
    checks++;
    if (HEX !== HEX_ELLO) begin
      errors++; $display("FAIL scroll_hex_ello: got %h expected %h", HEX, HEX_ELLO);
    end
  endtask

  task automatic test_wrap_hold();
    bit found;
    bit stayed;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      clk1();
      if (PTR === 3'd0) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL wrap_timeout: got ptr %0d expected 0 within 40 cycles", PTR);
    end
    checks++;
    if (WRAP !== 1'b1) begin
      errors++; $display("FAIL wrap_pulse: got %b expected 1", WRAP);
    end
    checks++;
    if (HEX !== HEX_BHEL) begin
      errors++; $display("FAIL wrap_hex_ptr7: got %h expected %h", HEX, HEX_BHEL);
    end
    clk1();
    checks++;
    if (WRAP !== 1'b0) begin
      errors++; $display("FAIL wrap_one_cycle: got %b expected 0", WRAP);
    end
    checks++;
    if (HEX !== HEX_HELL) begin
      errors++; $display("FAIL hold_hex: got %h expected %h", HEX, HEX_HELL);
    end
    // Hold adds two ticks to the normal one-tick dwell: ptr 0 for 12 cycles.
    stayed = 1'b1;
    repeat (10) begin
      clk1();
      if (PTR !== 3'd0) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin
      errors++; $display("FAIL hold_frozen: got ptr %0d expected 0 throughout", PTR);
    end
    clk1();
    checks++;
    if (PTR !== 3'd1) begin
      errors++; $display("FAIL hold_release: got %0d expected 1", PTR);
    end
  endtask

  task automatic test_step_right();
    RUN = 1'b0;
    DIR = 1'b1;
    clk1();
    checks++;
    if (PTR !== 3'd1) begin
      errors++; $display("FAIL pause_ptr: got %0d expected 1", PTR);
    end
    STEP = 1'b1; clk1();
    checks++;
    if (PTR !== 3'd0 || WRAP !== 1'b0) begin
      errors++; $display("FAIL step_1to0: got ptr %0d wrap %b expected ptr 0 wrap 0", PTR, WRAP);
    end
    STEP = 1'b0; clk1();
    STEP = 1'b1; clk1();
    checks++;
    if (PTR !== 3'd7 || WRAP !== 1'b1) begin
      errors++; $display("FAIL step_0to7: got ptr %0d wrap %b expected ptr 7 wrap 1", PTR, WRAP);
    end
    STEP = 1'b0; clk1();
    checks++;
    if (WRAP !== 1'b0) begin
      errors++; $display("FAIL step_wrap_clear: got %b expected 0", WRAP);
    end
    STEP = 1'b1; clk1();
    STEP = 1'b0; clk1();
    STEP = 1'b1; clk1();
    checks++;
    if (PTR !== 3'd5 || WRAP !== 1'b0) begin
      errors++; $display("FAIL step_to5: got ptr %0d wrap %b expected ptr 5 wrap 0", PTR, WRAP);
    end
    STEP = 1'b0; clk1();
    STEP = 1'b1; clk1();
    repeat (4) clk1();
    checks++;
    if (PTR !== 3'd4) begin
      errors++; $display("FAIL step_held: got %0d expected 4", PTR);
    end
    STEP = 1'b0; clk1();
  endtask

  task automatic test_write_step();
    DIR = 1'b0;
    repeat (3) begin
      STEP = 1'b1; clk1();
      STEP = 1'b0; clk1();
    end
    checks++;
    if (PTR !== 3'd7) begin
      errors++; $display("FAIL write_setup: got %0d expected 7", PTR);
    end
    STEP = 1'b1; WR_EN = 1'b1; WR_ADDR = 3'd0; WR_DATA = 3'd6;
    clk1();
    STEP = 1'b0; WR_EN = 1'b0;
    checks++;
    if (PTR !== 3'd0 || WRAP !== 1'b1 || HEX !== HEX_BHEL) begin
      errors++; $display("FAIL write_step_edge: got ptr %0d wrap %b hex %h expected ptr 0 wrap 1 hex %h",
                         PTR, WRAP, HEX, HEX_BHEL);
    end
    clk1();
    checks++;
    if (HEX !== HEX_UELL) begin
      errors++; $display("FAIL write_step_hex: got %h expected %h", HEX, HEX_UELL);
    end
    WR_EN = 1'b1; WR_ADDR = 3'd3; WR_DATA = 3'd5;
    clk1();
    WR_EN = 1'b0;
    checks++;
    if (HEX !== HEX_UELL) begin
      errors++; $display("FAIL write_latency: got %h expected %h", HEX, HEX_UELL);
    end
    clk1();
    checks++;
    if (HEX !== HEX_UELA) begin
      errors++; $display("FAIL write_slot3: got %h expected %h", HEX, HEX_UELA);
    end
  endtask

  task automatic test_reset_mid_hold();
    bit found;
    RUN = 1'b1;
    DIR = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      clk1();
      if (WRAP === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL hold_wrap_timeout: got wrap %b expected 1 within 60 cycles", WRAP);
    end
    repeat (3) clk1();
    RESETN = 1'b0;
    clk1();
    checks++;
    if (PTR !== 3'd0 || HEX !== 28'hFFFFFFF || WRAP !== 1'b0) begin
      errors++; $display("FAIL midhold_reset: got ptr %0d hex %h wrap %b expected ptr 0 hex fffffff wrap 0",
                         PTR, HEX, WRAP);
    end
    RESETN = 1'b1;
    clk1();
    checks++;
    if (HEX !== HEX_HELL) begin
      errors++; $display("FAIL midhold_buffer: got %h expected %h", HEX, HEX_HELL);
    end
    // Reset lands in PAUSE, so RUN=1 enters SCROLL one edge later.
    repeat (3) clk1();
    checks++;
    if (PTR !== 3'd0) begin
      errors++; $display("FAIL midhold_restart_early: got %0d expected 0", PTR);
    end
    clk1();
    checks++;
    if (PTR !== 3'd1) begin
      errors++; $display("FAIL midhold_restart_step: got %0d expected 1", PTR);
    end
  endtask

  initial begin
    test_reset();
    test_scroll_left();
    test_wrap_hold();
    test_step_right();
    test_write_step();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
